seq_det_1101: RTL

Moore-style serial pattern detector that consumes the registered bit stream produced by the team's one-bit Moore follower stage (its y output drives this block's x input). It recognises the pattern 1101 (oldest bit first) with overlap, flags each detection on a registered Moore output, and keeps a saturating count of detections. Its output feeds status/interrupt logic downstream.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_det_1101_if.sv | 31 +++
 rtl/sat_counter.sv | 34 +++
 rtl/seq_det_1101.sv | 56 +++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding and pattern constant for the 1101 detector
package seq_det_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_11   = 3'd2,
        S_110  = 3'd3,
        S_DET  = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_det_1101_if.sv
// rtl/seq_det_1101_if.sv - serial bit input and detection status bundle
interface seq_det_1101_if #(
    parameter int CNT_W = 8
);

    logic             x;
    logic             bit_vld;
    logic             clr;
    logic             det;
    logic [CNT_W-1:0] cnt;
    logic             cnt_sat;

    modport master (
        output x,
        output bit_vld,
        output clr,
        input  det,
        input  cnt,
        input  cnt_sat
    );

    modport slave (
        input  x,
        input  bit_vld,
        input  clr,
        output det,
        output cnt,
        output cnt_sat
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, clear has priority over increment
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_det_1101.sv
// rtl/seq_det_1101.sv - overlapping 1101 Moore detector with saturating detection count
module seq_det_1101
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_det_1101_if.slave  bus
);

    state_t state_q;
    state_t state_d;
    logic   inc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.bit_vld) state_d = bus.x ? S_1  : S_IDLE;
            S_1:    if (bus.bit_vld) state_d = bus.x ? S_11 : S_IDLE;
            S_11:   if (bus.bit_vld) state_d = bus.x ? S_11 : S_110;
            S_110:  if (bus.bit_vld) state_d = bus.x ? S_DET : S_IDLE;
            // the trailing 1 of a match plus a new 1 already forms the "11" prefix
            S_DET:  if (bus.bit_vld) state_d = bus.x ? S_11 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.clr) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // a stall inside S_DET keeps state_d at S_DET, so bit_vld gates the count
    assign inc = bus.bit_vld && !bus.clr && (state_d == S_DET);

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr),
        .inc (inc),
        .q   (bus.cnt)
    );

    assign bus.det     = (state_q == S_DET);
    assign bus.cnt_sat = &bus.cnt;

endmodule
